// File: rtl/led_mon_pkg.sv
// Shared constants and state encoding for the LED blink monitor.
package led_mon_pkg;

  localparam int unsigned DEF_CNT_W   = 29;
  localparam int unsigned DEF_TIMEOUT = 100_000_000;
  localparam int unsigned EDGE_W      = 16;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FIRST_HI = 3'd1;
  localparam logic [2:0] ST_FIRST_LO = 3'd2;
  localparam logic [2:0] ST_HIGH     = 3'd3;
  localparam logic [2:0] ST_LOW      = 3'd4;
  localparam logic [2:0] ST_STUCK    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_FIRST_HI = ST_FIRST_HI,
    S_FIRST_LO = ST_FIRST_LO,
    S_HIGH     = ST_HIGH,
    S_LOW      = ST_LOW,
    S_STUCK    = ST_STUCK
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous line plus one delay stage
// for single-cycle rise/fall detection on the synchronized level.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;
  assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/led_blink_monitor.sv
// Measures period and high time of an asynchronous blink line in clk cycles
// and flags a line that shows no edge for TIMEOUT cycles.
module led_blink_monitor
  import led_mon_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             led_in,
  input  logic             clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level,
  output logic [15:0]      edge_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

  logic level, rise, fall, any_edge, timeout_hit;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [CNT_W-1:0]    high_time_q, high_time_d;
  logic                meas_valid_q, meas_valid_d;
  logic                stuck_q, stuck_d;
  logic                stuck_level_q, stuck_level_d;

  sync_edge_det u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (led_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign any_edge    = rise | fall;
  assign timeout_hit = (state_q != S_STUCK) && !any_edge && (idle_cnt_q == IDLE_LAST);

  // Free-running measurement counters; both saturate so overflow reads as a ceiling.
  always_comb begin
    per_cnt_d  = per_cnt_q;
    idle_cnt_d = idle_cnt_q;
    edge_cnt_d = edge_cnt_q;
    if (clr) begin
      per_cnt_d  = '0;
      idle_cnt_d = '0;
      edge_cnt_d = '0;
    end else begin
      if (rise) begin
        per_cnt_d = CNT_W'(1);
      end else if (per_cnt_q != CNT_MAX) begin
        per_cnt_d = per_cnt_q + CNT_W'(1);
      end
      if (any_edge) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q != IDLE_MAX) begin
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
      if (rise) begin
        edge_cnt_d = edge_cnt_q + EDGE_W'(1);
      end
    end
  end

  // Next-state and measurement capture.
  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    high_time_d   = high_time_q;
    meas_valid_d  = 1'b0;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;

    if (clr) begin
      state_d       = S_IDLE;
      period_d      = '0;
      high_time_d   = '0;
      stuck_d       = 1'b0;
      stuck_level_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rise) state_d = S_FIRST_HI;
        end
        S_FIRST_HI: begin
          if (fall) begin
            state_d     = S_FIRST_LO;
            high_time_d = per_cnt_q;
          end
        end
        S_FIRST_LO, S_LOW: begin
          if (rise) begin
            state_d      = S_HIGH;
            period_d     = per_cnt_q;
            meas_valid_d = 1'b1;
          end
        end
        S_HIGH: begin
          if (fall) begin
            state_d     = S_LOW;
            high_time_d = per_cnt_q;
          end
        end
        S_STUCK: begin
          if (rise) begin
            state_d = S_FIRST_HI;
            stuck_d = 1'b0;
          end else if (fall) begin
            state_d = S_IDLE;
            stuck_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // An edge in the same cycle always wins over the timeout.
      if (timeout_hit) begin
        state_d       = S_STUCK;
        stuck_d       = 1'b1;
        stuck_level_d = level;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      per_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      edge_cnt_q    <= '0;
      period_q      <= '0;
      high_time_q   <= '0;
      meas_valid_q  <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      per_cnt_q     <= per_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      edge_cnt_q    <= edge_cnt_d;
      period_q      <= period_d;
      high_time_q   <= high_time_d;
      meas_valid_q  <= meas_valid_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign period      = period_q;
  assign high_time   = high_time_q;
  assign meas_valid  = meas_valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;
  assign edge_cnt    = edge_cnt_q;

endmodule

// File: tb/tb_led_blink_monitor.sv
// Directed bench for led_blink_monitor: scoreboarded meas_valid pulses plus
// point checks of stuck detection, clear, wrap and saturation behaviour.
module tb_led_blink_monitor;
  import led_mon_pkg::*;

  localparam int unsigned CW  = 29;
  localparam int unsigned TO  = 64;
  localparam int unsigned SCW = 6;
  localparam int unsigned STO = 63;

  logic clk = 1'b0;
  logic rst_n, led_in, clr, led_s, clr_s;

  logic [CW-1:0]  period, high_time;
  logic           meas_valid, stuck, stuck_level;
  logic [15:0]    edge_cnt;
  logic [SCW-1:0] period_s, high_time_s;
  logic           meas_valid_s, stuck_s, stuck_level_s;
  logic [15:0]    edge_cnt_s;

  always #5 clk = ~clk;

  led_blink_monitor #(.CNT_W(CW), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .led_in(led_in), .clr(clr),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .stuck(stuck), .stuck_level(stuck_level), .edge_cnt(edge_cnt)
  );

  led_blink_monitor #(.CNT_W(SCW), .TIMEOUT(STO)) u_sat (
    .clk(clk), .rst_n(rst_n), .led_in(led_s), .clr(clr_s),
    .period(period_s), .high_time(high_time_s), .meas_valid(meas_valid_s),
    .stuck(stuck_s), .stuck_level(stuck_level_s), .edge_cnt(edge_cnt_s)
  );

  typedef struct packed {
    logic [CW-1:0] per;
    logic [CW-1:0] hi;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic push(input int per, input int hi);
    exp_t e;
    e.per = CW'(per);
    e.hi  = CW'(hi);
    sb.push_back(e);
  endtask

  // Hold the line at v for n sampling edges; returns 1 time unit after the last edge.
  task automatic run(input logic v, input int n);
    led_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  // n full periods starting from IDLE; every rise after the first closes a period.
  task automatic square(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) push(h + l, h);
      run(1'b1, h);
      run(1'b0, l);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"},      32'(period),      32'd0);
    chk({tag, "_high_time"},   32'(high_time),   32'd0);
    chk({tag, "_meas_valid"},  32'(meas_valid),  32'd0);
    chk({tag, "_stuck"},       32'(stuck),       32'd0);
    chk({tag, "_stuck_level"}, 32'(stuck_level), 32'd0);
    chk({tag, "_edge_cnt"},    32'(edge_cnt),    32'd0);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_pending_meas"}, 32'(sb.size()), 32'd0);
  endtask

  // Every meas_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && meas_valid) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_meas_valid: observed pulse period %0d expected no pulse", period);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_period",    32'(period),    32'(e.per));
        chk("mon_high_time", 32'(high_time), 32'(e.hi));
      end
    end
  end

  initial begin
    bit found;
    rst_n  = 1'b0;
    led_in = 1'b0;
    clr    = 1'b0;
    led_s  = 1'b0;
    clr_s  = 1'b0;

    // Reset held while the line toggles.
    for (int i = 0; i < 6; i++) run(1'(i % 2), 2);
    chk_zero("rst_hold");
    chk("rst_hold_state", 32'(u_dut.state_q), 32'(S_IDLE));
    run(1'b0, 3);
    rst_n = 1'b1;
    square(10, 10, 3);
    chk("sq10_period",    32'(period),    32'd20);
    chk("sq10_high_time", 32'(high_time), 32'd10);
    chk("sq10_edge_cnt",  32'(edge_cnt),  32'd3);
    chk_drained("sq10");

    // Asynchronous reset mid-run.
    push(20, 10);
    run(1'b1, 4);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_async");
    run(1'b0, 3);
    run(1'b1, 3);
    run(1'b0, 3);
    chk_zero("rst_toggle");
    rst_n = 1'b1;
    square(10, 10, 2);
    chk("post_rst_period",    32'(period),    32'd20);
    chk("post_rst_high_time", 32'(high_time), 32'd10);
    chk("post_rst_edge_cnt",  32'(edge_cnt),  32'd2);
    chk_drained("post_rst");

    // Duty change.
    pulse_clr();
    square(5, 15, 3);
    chk("duty_period",    32'(period),    32'd20);
    chk("duty_high_time", 32'(high_time), 32'd5);
    chk("duty_edge_cnt",  32'(edge_cnt),  32'd3);
    chk_drained("duty");

    // Stuck high: rise lands its effects 3 edges after driving, stuck 64 edges later.
    push(20, 5);
    run(1'b1, 66);
    chk("stuck_before", 32'(stuck), 32'd0);
    run(1'b1, 1);
    chk("stuck_set",       32'(stuck),          32'd1);
    chk("stuck_level_hi",  32'(stuck_level),    32'd1);
    chk("stuck_state",     32'(u_dut.state_q),  32'(S_STUCK));
    run(1'b1, 10);
    chk("stuck_hold", 32'(stuck), 32'd1);
    run(1'b0, 2);
    chk("stuck_pre_fall", 32'(stuck), 32'd1);
    run(1'b0, 1);
    chk("stuck_cleared",        32'(stuck),         32'd0);
    chk("stuck_fall_state",     32'(u_dut.state_q), 32'(S_IDLE));
    chk("stuck_period_hold",    32'(period),        32'd20);
    chk("stuck_high_time_hold", 32'(high_time),     32'd5);
    chk_drained("stuck");

    // Rise arrives in the cycle idle_cnt reaches TIMEOUT-1.
    pulse_clr();
    run(1'b0, 61);
    run(1'b1, 2);
    chk("tie_idle_cnt", 32'(u_dut.idle_cnt_q), 32'd63);
    chk("tie_stuck_pre", 32'(stuck), 32'd0);
    run(1'b1, 1);
    chk("tie_stuck",    32'(stuck),         32'd0);
    chk("tie_state",    32'(u_dut.state_q), 32'(S_FIRST_HI));
    chk("tie_edge_cnt", 32'(edge_cnt),      32'd1);
    run(1'b1, 7);
    run(1'b0, 10);
    push(20, 10);
    run(1'b1, 6);
    run(1'b0, 10);
    chk("tie_period",    32'(period),        32'd20);
    chk("tie_high_time", 32'(high_time),     32'd6);
    chk("tie_low_state", 32'(u_dut.state_q), 32'(S_LOW));
    chk_drained("tie");

    // Clear coinciding with a rise that would have closed a period.
    run(1'b1, 2);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk_zero("clr");
    chk("clr_state", 32'(u_dut.state_q), 32'(S_IDLE));
    run(1'b1, 5);
    run(1'b0, 10);
    run(1'b1, 10);
    run(1'b0, 20);
    push(30, 10);
    run(1'b1, 5);
    run(1'b0, 5);
    chk("clr_period",    32'(period),    32'd30);
    chk("clr_high_time", 32'(high_time), 32'd5);
    chk("clr_edge_cnt",  32'(edge_cnt),  32'd2);
    chk_drained("clr");

    // Edge counter wrap; preload near the top to keep the run short.
    force u_dut.edge_cnt_q = 16'hFFFE;
    run(1'b0, 2);
    release u_dut.edge_cnt_q;
    chk("wrap_preload", 32'(edge_cnt), 32'h0000FFFE);
    push(12, 5);
    run(1'b1, 3);
    chk("wrap_ffff", 32'(edge_cnt), 32'h0000FFFF);
    run(1'b0, 3);
    push(6, 3);
    run(1'b1, 3);
    chk("wrap_zero", 32'(edge_cnt), 32'h00000000);
    run(1'b0, 5);
    chk_drained("wrap");

    // Narrow counters: idle line is stuck low, then a 70-cycle period saturates.
    chk("sat_stuck",       32'(stuck_s),       32'd1);
    chk("sat_stuck_level", 32'(stuck_level_s), 32'd0);
    led_s = 1'b1;
    repeat (35) begin @(posedge clk); #1; end
    led_s = 1'b0;
    repeat (35) begin @(posedge clk); #1; end
    led_s = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (meas_valid_s) begin
        found = 1'b1;
        break;
      end
    end
    chk("sat_meas_valid", 32'(found), 32'd1);
    chk("sat_period",     32'(period_s),    32'd63);
    chk("sat_high_time",  32'(high_time_s), 32'd35);
    chk("sat_stuck_clr",  32'(stuck_s),     32'd0);
    chk("sat_edge_cnt",   32'(edge_cnt_s),  32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
